// File: rtl/rr_arb_1hot_sel.sv
// rr_arb_1hot_sel: round-robin arbiter producing a registered one-hot select
// for a downstream one-hot mux with default (all-zero select = default input).
// A winner keeps its grant while it requests. Dropping the request releases
// the grant and rotates priority to the next index.
// Optional build macro RR_ARB_1HOT_HOLD_LIMIT_EN: pre-empt a holder after
// HOLD_MAX consecutive grant cycles, but only when another requester is waiting.
module rr_arb_1hot_sel #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N-1:0]                        req,
  output logic [N-1:0]                        gnt,
  output logic                                gnt_vld,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx
);

  localparam int          IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NU = N;

  // Reject illegal configurations at elaboration time.
  if (N < 2 || N > 32) begin : g_bad_n
    $error("rr_arb_1hot_sel: N must be in 2..32");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("rr_arb_1hot_sel: HOLD_MAX must be >= 1");
  end

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  nxt_h;
  logic [IW-1:0]  start;
  logic [N-1:0]   mreq;
  logic [N-1:0]   onehot;
  logic [IW-1:0]  win;
  logic           found;
  logic           preempt;
  logic           rel;
  int unsigned    pos;

  // Pick the winner: the first set bit of the candidate requests, scanning
  // upward from the start index with wrap-around modulo N.
  always_comb begin
    nxt_h  = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    start  = (state == IDLE) ? ptr : nxt_h;
    mreq   = (state == IDLE) ? req : (req & ~gnt);
    found  = 1'b0;
    win    = '0;
    pos    = 0;
    for (int unsigned off = 0; off < NU; off++) begin
      pos = 32'(start) + off;
      if (pos >= NU) pos = pos - NU;
      if (!found && mreq[IW'(pos)]) begin
        found = 1'b1;
        win   = IW'(pos);
      end
    end
    onehot      = '0;
    onehot[win] = 1'b1;
  end

`ifdef RR_ARB_1HOT_HOLD_LIMIT_EN
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [HW-1:0] hcnt;
  logic          hold_full;

  assign hold_full = (hcnt == HW'(HOLD_MAX - 1));
  // In GRANT, mreq already excludes the holder, so this means "someone else waits".
  assign preempt   = hold_full && (mreq != '0);

  // Count consecutive grant cycles of the current holder, saturating at HOLD_MAX-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
    end else if (state == IDLE || rel) begin
      hcnt <= '0;
    end else if (!hold_full) begin
      hcnt <= hcnt + HW'(1);
    end
  end
`else
  assign preempt = 1'b0;
`endif

  // A pre-emption is handled exactly like a voluntary release.
  assign rel = (state == GRANT) && (!req[gnt_idx] || preempt);

  // Grant FSM: all outputs are registered; release and re-grant share one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            gnt     <= onehot;
            gnt_vld <= 1'b1;
            gnt_idx <= win;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr <= nxt_h;
            if (found) begin
              gnt     <= onehot;
              gnt_idx <= win;
            end else begin
              state   <= IDLE;
              gnt     <= '0;
              gnt_vld <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arb_1hot_sel.md
Name: rr_arb_1hot_sel

Overview:
- Round-robin arbiter producing the one-hot select vector that drives the downstream 8-way one-hot mux with default.
- Registers one winner among N requesters and holds the grant while the winner keeps requesting.
- Releases and rotates priority when the winner drops its request.
- When nothing is granted, the select vector is all-zero, so the downstream mux outputs its default input.

Parameters:
- N, 8, number of requesters/select bits; legal range 2..32; must match the downstream mux select width.
- HOLD_MAX, 4, maximum consecutive grant cycles per holder; used only when the optional feature is compiled in; legal range >=1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request level; bit i = requester i.
- gnt  output  N  registered one-hot grant; feeds the mux sel directly; all-zero = none granted.
- gnt_vld  output  1  high when gnt is non-zero.
- gnt_idx  output  max(1,$clog2(N))  binary index of the granted bit; holds the last holder when gnt_vld=0.

Behaviour:
- Reset values (rst sampled high at an edge): gnt=0, gnt_vld=0, gnt_idx=0, priority pointer ptr=0, hold counter hcnt=0, state=IDLE.
  - Reset overrides all other activity, including mid-grant.
- All outputs are registered. No combinational path from req to gnt.
- State IDLE (gnt=0):
  - If req!=0 at an edge, go to GRANT.
  - Winner = first set bit of req scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap-around).
  - Set gnt = 1<<winner, gnt_idx = winner, hcnt = 0.
  - Latency req->gnt is 1 cycle. If req==0, remain in IDLE.
- State GRANT, holder h:
  - If req[h]=1 at an edge, keep the grant; hcnt increments, saturating at HOLD_MAX-1.
  - If req[h]=0 at an edge, release: ptr <= (h+1) mod N.
    - If (req with bit h masked) != 0, grant the next winner scanning from (h+1) mod N in the same edge. This is back-to-back with no idle bubble; hcnt = 0.
    - Otherwise go to IDLE: gnt=0, gnt_vld=0.
- Invariants:
  - gnt is never multi-hot.
  - gnt changes only at clock edges.
  - A requester never receives a grant for a cycle in which its req was 0 at the deciding edge.
- Fairness: with all N requesting and each holder releasing after its turn, every requester is granted once per N grants.
- Wrap-around: ptr = N-1 scans bit N-1 first, then bit 0.
- req bits above N-1 do not exist. Index arithmetic is modulo N, including non-power-of-2 N.

Optional Feature:
- Macro: RR_ARB_1HOT_HOLD_LIMIT_EN.
- When defined, a holder whose hcnt=HOLD_MAX-1 and req[h]=1 is pre-empted at the next edge, but only if another requester is pending.
  - Pre-emption is a release: ptr <= (h+1) mod N, next winner is chosen as in a normal release, hcnt = 0.
  - If no other requester is pending, the grant is kept and hcnt stays saturated.
- When not defined, hcnt logic is absent, HOLD_MAX is ignored, and the holder keeps the grant for as long as req[h]=1.

Test Plan:
- Reset: req=8'hFF with rst=1 for 3 cycles -> gnt=0, gnt_vld=0, gnt_idx=0 throughout. First edge after rst=0 -> gnt=8'h01, gnt_idx=0.
- Single requester: idle, req=8'h10 -> gnt=8'h10, gnt_idx=4 one cycle later. Held 20 cycles with req steady (feature off). req=0 -> gnt=0 the next cycle.
- Rotation: req=8'h05, holder drops its bit for exactly the cycle after being granted 3 cycles -> grant sequence 8'h01, 8'h04, 8'h01, with no idle cycle between grants.
- Wrap: grant to bit 6 then release, leaving ptr=7; req=8'h41 -> next gnt=8'h01, not 8'h40.
- Hold limit (macro defined, HOLD_MAX=4): req=8'h03 constant -> gnt 8'h01 for 4 cycles, 8'h02 for 4, then 8'h01. With req=8'h01 alone -> 8'h01 held indefinitely.
- Reset mid-grant: gnt=8'h08 held, rst pulsed 1 cycle with req=8'hFF -> gnt=0 after the rst edge, then gnt=8'h01 (ptr reset to 0).
